// File: rtl/trail_access_scheduler_if.sv
// rtl/trail_access_scheduler_if.sv - push/backtrack bus between producers, scheduler and trail manager
//
// Purpose: bundles every signal of trail_access_scheduler except clk/reset.
//   master modport : the surroundings (push producers, backtrack requester, trail manager)
//   slave  modport : trail_access_scheduler itself
// Signal summary:
//   req_valid/req_ready/req_var/req_value/req_is_decision/req_reason : NUM_REQ push requesters
//   bt_req/bt_level/bt_ack                                          : backtrack request handshake
//   tm_push*/tm_backtrack_en/tm_backtrack_to_level                  : commands to the trail manager
//   tm_backtrack_done/tm_height                                     : status from the trail manager
//   level/busy/overflow                                             : scheduler status
// Optional: TRAIL_SCHED_STATS_EN adds stat_pushes, stat_backtracks, stat_stall_cycles.
interface trail_access_scheduler_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_var;
  logic [NUM_REQ-1:0]    req_value;
  logic [NUM_REQ-1:0]    req_is_decision;
  logic [NUM_REQ*16-1:0] req_reason;

  logic                  bt_req;
  logic [15:0]           bt_level;
  logic                  bt_ack;

  logic                  tm_push;
  logic [31:0]           tm_push_var;
  logic                  tm_push_value;
  logic [15:0]           tm_push_level;
  logic                  tm_push_is_decision;
  logic [15:0]           tm_push_reason;
  logic                  tm_backtrack_en;
  logic [15:0]           tm_backtrack_to_level;
  logic                  tm_backtrack_done;
  logic [15:0]           tm_height;

  logic [15:0]           level;
  logic                  busy;
  logic                  overflow;

`ifdef TRAIL_SCHED_STATS_EN
  logic [31:0]           stat_pushes;
  logic [31:0]           stat_backtracks;
  logic [31:0]           stat_stall_cycles;
`endif

  modport master (
    output req_valid, req_var, req_value, req_is_decision, req_reason,
    output bt_req, bt_level,
    output tm_backtrack_done, tm_height,
    input  req_ready, bt_ack,
    input  tm_push, tm_push_var, tm_push_value, tm_push_level, tm_push_is_decision, tm_push_reason,
    input  tm_backtrack_en, tm_backtrack_to_level,
    input  level, busy, overflow
`ifdef TRAIL_SCHED_STATS_EN
    , input stat_pushes, stat_backtracks, stat_stall_cycles
`endif
  );

  modport slave (
    input  req_valid, req_var, req_value, req_is_decision, req_reason,
    input  bt_req, bt_level,
    input  tm_backtrack_done, tm_height,
    output req_ready, bt_ack,
    output tm_push, tm_push_var, tm_push_value, tm_push_level, tm_push_is_decision, tm_push_reason,
    output tm_backtrack_en, tm_backtrack_to_level,
    output level, busy, overflow
`ifdef TRAIL_SCHED_STATS_EN
    , output stat_pushes, stat_backtracks, stat_stall_cycles
`endif
  );
endinterface

// File: rtl/trail_access_scheduler.sv
// rtl/trail_access_scheduler.sv - round-robin push arbiter and backtrack sequencer for the trail manager
//
// Purpose: sole owner of the trail manager's push and backtrack ports. Grants one
//   assignment push per cycle among NUM_REQ producers (round-robin), tags each push
//   with its decision level, and sequences backtracks (issue, wait for done, settle)
//   while holding all producers off.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high
//   bus   : trail_access_scheduler_if.slave (requests, backtrack handshake, trail
//           manager command/status, level/busy/overflow status)
// Parameters:
//   NUM_REQ  : number of push requesters; index 0 starts with round-robin priority
//   MAX_VARS : trail capacity, equal to the trail manager's MAX_VARS
// Optional: define TRAIL_SCHED_STATS_EN for saturating push/backtrack/stall counters.
module trail_access_scheduler #(
  parameter int NUM_REQ  = 3,
  parameter int MAX_VARS = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  trail_access_scheduler_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_BT_ISSUE  = 2'd1,
    ST_BT_WAIT   = 2'd2,
    ST_BT_SETTLE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  // r_rr_ptr holds the index with highest priority (one past the last grant)
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   w_rr_ptr_nxt;
  logic [15:0]        r_level;
  logic [15:0]        r_bt_target;
  logic               r_overflow;

  logic               r_push;
  logic [31:0]        r_push_var;
  logic               r_push_value;
  logic [15:0]        r_push_level;
  logic               r_push_is_decision;
  logic [15:0]        r_push_reason;

  logic [31:0]        w_occ;
  logic               w_full;
  logic               w_any_valid;

  logic [NUM_REQ-1:0] w_ge_ptr;
  logic [NUM_REQ-1:0] w_valid_hi;
  logic [NUM_REQ-1:0] w_pick_src;
  logic [NUM_REQ-1:0] w_onehot;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_push_fire;

  logic [31:0]        w_sel_var;
  logic               w_sel_value;
  logic               w_sel_is_decision;
  logic [15:0]        w_sel_reason;
  logic [15:0]        w_level_inc;
  logic [15:0]        w_sel_level;

  logic               w_grant_en;
  logic               w_bt_accept;
  logic               w_bt_en;
  logic               w_bt_take;
  logic               w_bt_ack;

  // Occupancy counts the push already registered toward the trail, since the
  // trail's tm_height does not include it yet.
  assign w_occ       = {16'd0, bus.tm_height} + {31'd0, r_push};
  assign w_full      = (w_occ >= 32'(MAX_VARS));
  assign w_any_valid = |bus.req_valid;

  // Round-robin pick: lowest valid index at or above the pointer, else lowest
  // valid index overall (wrap-around). x & -x isolates the lowest set bit.
  always_comb begin
    w_ge_ptr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_ge_ptr[i] = (i >= int'(r_rr_ptr));
    end
    w_valid_hi = bus.req_valid & w_ge_ptr;
    w_pick_src = (|w_valid_hi) ? w_valid_hi : bus.req_valid;
    w_onehot   = w_pick_src & (~w_pick_src + NUM_REQ'(1));
  end

  always_comb begin
    w_sel_var         = '0;
    w_sel_value       = 1'b0;
    w_sel_is_decision = 1'b0;
    w_sel_reason      = '0;
    w_rr_ptr_nxt      = r_rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_onehot[i]) begin
        w_sel_var         = bus.req_var[32*i +: 32];
        w_sel_value       = bus.req_value[i];
        w_sel_is_decision = bus.req_is_decision[i];
        w_sel_reason      = bus.req_reason[16*i +: 16];
        w_rr_ptr_nxt      = (i == NUM_REQ - 1) ? '0 : IDX_W'(i + 1);
      end
    end
  end

  // Decision pushes open a new level; saturate instead of wrapping.
  assign w_level_inc = (r_level == 16'hFFFF) ? r_level : r_level + 16'd1;
  assign w_sel_level = w_sel_is_decision ? w_level_inc : r_level;

  assign w_grant     = w_grant_en ? w_onehot : '0;
  assign w_push_fire = |w_grant;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and control strobes. A pending backtrack request beats any
  // push in RUN; pushes are only granted while the trail has room.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    w_bt_accept = 1'b0;
    w_bt_en     = 1'b0;
    w_bt_take   = 1'b0;
    w_bt_ack    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.bt_req) begin
          w_bt_accept = 1'b1;
          w_state_nxt = ST_BT_ISSUE;
        end else begin
          w_grant_en = !w_full;
        end
      end
      ST_BT_ISSUE: begin
        w_bt_en     = 1'b1;
        w_state_nxt = ST_BT_WAIT;
      end
      ST_BT_WAIT: begin
        if (bus.tm_backtrack_done) begin
          w_bt_take   = 1'b1;
          w_state_nxt = ST_BT_SETTLE;
        end
      end
      ST_BT_SETTLE: begin
        // Quiet cycle: the trail writes its new height back now.
        w_bt_ack    = 1'b1;
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_level     <= '0;
      r_bt_target <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push_fire) begin
        r_rr_ptr <= w_rr_ptr_nxt;
      end
      if (w_bt_accept) begin
        r_bt_target <= bus.bt_level;
      end
      // A target above the current level is accepted as-is.
      if (w_bt_take) begin
        r_level <= r_bt_target;
      end else if (w_push_fire && w_sel_is_decision) begin
        r_level <= w_level_inc;
      end
      if (w_full && w_any_valid) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_push             <= 1'b0;
      r_push_var         <= '0;
      r_push_value       <= 1'b0;
      r_push_level       <= '0;
      r_push_is_decision <= 1'b0;
      r_push_reason      <= '0;
    end else begin
      r_push <= w_push_fire;
      if (w_push_fire) begin
        r_push_var         <= w_sel_var;
        r_push_value       <= w_sel_value;
        r_push_level       <= w_sel_level;
        r_push_is_decision <= w_sel_is_decision;
        r_push_reason      <= w_sel_reason;
      end
    end
  end

  assign bus.req_ready             = w_grant;
  assign bus.bt_ack                = w_bt_ack;
  assign bus.tm_push               = r_push;
  assign bus.tm_push_var           = r_push_var;
  assign bus.tm_push_value         = r_push_value;
  assign bus.tm_push_level         = r_push_level;
  assign bus.tm_push_is_decision   = r_push_is_decision;
  assign bus.tm_push_reason        = r_push_reason;
  assign bus.tm_backtrack_en       = w_bt_en;
  assign bus.tm_backtrack_to_level = r_bt_target;
  assign bus.level                 = r_level;
  assign bus.busy                  = (r_state != ST_RUN);
  assign bus.overflow              = r_overflow;

`ifdef TRAIL_SCHED_STATS_EN
  logic [31:0] r_stat_pushes;
  logic [31:0] r_stat_backtracks;
  logic [31:0] r_stat_stall_cycles;
  logic        w_stall;

  assign w_stall = w_any_valid && !w_push_fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_pushes       <= '0;
      r_stat_backtracks   <= '0;
      r_stat_stall_cycles <= '0;
    end else begin
      if (r_push && (r_stat_pushes != '1)) begin
        r_stat_pushes <= r_stat_pushes + 32'd1;
      end
      if (w_bt_ack && (r_stat_backtracks != '1)) begin
        r_stat_backtracks <= r_stat_backtracks + 32'd1;
      end
      if (w_stall && (r_stat_stall_cycles != '1)) begin
        r_stat_stall_cycles <= r_stat_stall_cycles + 32'd1;
      end
    end
  end

  assign bus.stat_pushes       = r_stat_pushes;
  assign bus.stat_backtracks   = r_stat_backtracks;
  assign bus.stat_stall_cycles = r_stat_stall_cycles;
`endif

endmodule

// File: tb/tb_trail_access_scheduler.sv
// tb/tb_trail_access_scheduler.sv - self-checking bench for trail_access_scheduler
`timescale 1ns/1ps
module tb_trail_access_scheduler;
  localparam int NUM_REQ  = 3;
  localparam int MAX_VARS = 256;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;

  trail_access_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  trail_access_scheduler #(.NUM_REQ(NUM_REQ), .MAX_VARS(MAX_VARS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  task automatic clear_inputs();
    bus.req_valid         = '0;
    bus.req_var           = '0;
    bus.req_value         = '0;
    bus.req_is_decision   = '0;
    bus.req_reason        = '0;
    bus.bt_req            = 1'b0;
    bus.bt_level          = '0;
    bus.tm_backtrack_done = 1'b0;
    bus.tm_height         = '0;
  endtask

  task automatic set_req(input int r, input logic v, input logic [31:0] vr, input logic val,
                         input logic dec, input logic [15:0] rsn);
    bus.req_valid[r]            = v;
    bus.req_var[32*r +: 32]     = vr;
    bus.req_value[r]            = val;
    bus.req_is_decision[r]      = dec;
    bus.req_reason[16*r +: 16]  = rsn;
  endtask

  // Leaves the bench just after a falling edge with reset released.
  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++;
    if (bus.req_ready !== 3'b000) begin
      n_bad++; $display("FAIL reset_ready got %b want 000", bus.req_ready);
    end
    n_vec++;
    if ({bus.tm_push, bus.tm_push_var, bus.tm_push_value, bus.tm_push_level,
         bus.tm_push_is_decision, bus.tm_push_reason} !== 67'd0) begin
      n_bad++; $display("FAIL reset_push got %h want 0", {bus.tm_push, bus.tm_push_var});
    end
    n_vec++;
    if ({bus.tm_backtrack_en, bus.tm_backtrack_to_level, bus.bt_ack} !== 18'd0) begin
      n_bad++; $display("FAIL reset_bt got %h want 0", {bus.tm_backtrack_en, bus.tm_backtrack_to_level, bus.bt_ack});
    end
    n_vec++;
    if ({bus.level, bus.busy, bus.overflow} !== 18'd0) begin
      n_bad++; $display("FAIL reset_status got %h want 0", {bus.level, bus.busy, bus.overflow});
    end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_r;
    logic [31:0] exp_var;
    do_reset();
    for (int r = 0; r < NUM_REQ; r++) set_req(r, 1'b1, 32'(100 + r), 1'b1, 1'b1, 16'hFFFF);
    for (int k = 0; k < 5; k++) begin
      #1;
      exp_r = (k < 4) ? (3'b001 << (k % 3)) : 3'b000;
      n_vec++;
      if (bus.req_ready !== exp_r) begin
        n_bad++; $display("FAIL rr_grant step %0d got %b want %b", k, bus.req_ready, exp_r);
      end
      n_vec++;
      if (bus.level !== 16'(k)) begin
        n_bad++; $display("FAIL rr_level step %0d got %0d want %0d", k, bus.level, k);
      end
      if (k >= 1) begin
        exp_var = 32'(100 + ((k - 1) % 3));
        n_vec++;
        if ({bus.tm_push, bus.tm_push_var, bus.tm_push_level, bus.tm_push_is_decision} !==
            {1'b1, exp_var, 16'(k), 1'b1}) begin
          n_bad++; $display("FAIL rr_push step %0d got push=%b var=%0d lvl=%0d want push=1 var=%0d lvl=%0d",
                            k, bus.tm_push, bus.tm_push_var, bus.tm_push_level, exp_var, k);
        end
      end
      @(negedge clk);
      if (k == 3) bus.req_valid = '0;
    end
  endtask

  // Ends at level 2 with round-robin pointer at 2.
  task automatic test_implied_push();
    do_reset();
    set_req(0, 1'b1, 32'd5, 1'b0, 1'b1, 16'hFFFF);
    repeat (2) @(negedge clk);
    set_req(0, 1'b0, 32'd0, 1'b0, 1'b0, 16'h0000);
    set_req(1, 1'b1, 32'd7, 1'b1, 1'b0, 16'h0012);
    #1;
    n_vec++;
    if (bus.req_ready !== 3'b010 || bus.level !== 16'd2) begin
      n_bad++; $display("FAIL implied_grant got ready=%b level=%0d want ready=010 level=2", bus.req_ready, bus.level);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    n_vec++;
    if ({bus.tm_push, bus.tm_push_var, bus.tm_push_value, bus.tm_push_level, bus.tm_push_is_decision, bus.tm_push_reason}
        !== {1'b1, 32'd7, 1'b1, 16'd2, 1'b0, 16'h0012}) begin
      n_bad++; $display("FAIL implied_push got push=%b var=%0d val=%b lvl=%0d dec=%b rsn=%h want 1/7/1/2/0/0012",
                        bus.tm_push, bus.tm_push_var, bus.tm_push_value, bus.tm_push_level,
                        bus.tm_push_is_decision, bus.tm_push_reason);
    end
    n_vec++;
    if (bus.level !== 16'd2) begin
      n_bad++; $display("FAIL implied_level got %0d want 2", bus.level);
    end
  endtask

  // Runs on from test_implied_push (level 2).
  task automatic test_backtrack();
    @(negedge clk);
    set_req(0, 1'b1, 32'd9, 1'b0, 1'b1, 16'hFFFF);
    bus.bt_req = 1'b1; bus.bt_level = 16'd1;
    #1;
    n_vec++;
    if (bus.req_ready !== 3'b000) begin
      n_bad++; $display("FAIL bt_priority got ready=%b want 000", bus.req_ready);
    end
    @(negedge clk);
    bus.tm_backtrack_done = 1'b1;
    #1;
    n_vec++;
    if ({bus.tm_backtrack_en, bus.tm_backtrack_to_level, bus.tm_push, bus.busy, bus.req_ready}
        !== {1'b1, 16'd1, 1'b0, 1'b1, 3'b000}) begin
      n_bad++; $display("FAIL bt_issue got en=%b to=%0d push=%b busy=%b ready=%b want 1/1/0/1/000",
                        bus.tm_backtrack_en, bus.tm_backtrack_to_level, bus.tm_push, bus.busy, bus.req_ready);
    end
    @(negedge clk);
    bus.tm_backtrack_done = 1'b0;
    #1;
    n_vec++;
    if ({bus.tm_backtrack_en, bus.bt_ack, bus.busy, bus.req_ready} !== {1'b0, 1'b0, 1'b1, 3'b000}) begin
      n_bad++; $display("FAIL bt_wait_early_done got en=%b ack=%b busy=%b ready=%b want 0/0/1/000",
                        bus.tm_backtrack_en, bus.bt_ack, bus.busy, bus.req_ready);
    end
    @(negedge clk);
    bus.tm_backtrack_done = 1'b1;
    #1;
    n_vec++;
    if ({bus.bt_ack, bus.req_ready, bus.level} !== {1'b0, 3'b000, 16'd2}) begin
      n_bad++; $display("FAIL bt_wait got ack=%b ready=%b level=%0d want 0/000/2", bus.bt_ack, bus.req_ready, bus.level);
    end
    @(negedge clk);
    bus.tm_backtrack_done = 1'b0;
    #1;
    n_vec++;
    if ({bus.bt_ack, bus.req_ready, bus.level} !== {1'b1, 3'b000, 16'd1}) begin
      n_bad++; $display("FAIL bt_settle got ack=%b ready=%b level=%0d want 1/000/1", bus.bt_ack, bus.req_ready, bus.level);
    end
    bus.bt_req = 1'b0;
    @(negedge clk);
    #1;
    n_vec++;
    if ({bus.bt_ack, bus.busy, bus.req_ready} !== {1'b0, 1'b0, 3'b001}) begin
      n_bad++; $display("FAIL bt_resume got ack=%b busy=%b ready=%b want 0/0/001", bus.bt_ack, bus.busy, bus.req_ready);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    n_vec++;
    if ({bus.tm_push, bus.tm_push_var, bus.tm_push_level} !== {1'b1, 32'd9, 16'd2}) begin
      n_bad++; $display("FAIL bt_after_push got push=%b var=%0d lvl=%0d want 1/9/2",
                        bus.tm_push, bus.tm_push_var, bus.tm_push_level);
    end
  endtask

  task automatic test_full();
    do_reset();
    bus.tm_height = 16'd255;
    set_req(0, 1'b1, 32'd1, 1'b0, 1'b1, 16'hFFFF);
    #1;
    n_vec++;
    if (bus.req_ready !== 3'b001) begin
      n_bad++; $display("FAIL full_255_idle got ready=%b want 001", bus.req_ready);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if ({bus.tm_push, bus.req_ready, bus.overflow} !== {1'b1, 3'b000, 1'b0}) begin
      n_bad++; $display("FAIL full_inflight got push=%b ready=%b ovf=%b want 1/000/0", bus.tm_push, bus.req_ready, bus.overflow);
    end
    @(negedge clk);
    bus.tm_height = 16'd256;
    #1;
    n_vec++;
    if ({bus.tm_push, bus.req_ready, bus.overflow} !== {1'b0, 3'b000, 1'b1}) begin
      n_bad++; $display("FAIL full_256 got push=%b ready=%b ovf=%b want 0/000/1", bus.tm_push, bus.req_ready, bus.overflow);
    end
    @(negedge clk);
    bus.tm_height = 16'd200;
    #1;
    n_vec++;
    if ({bus.req_ready, bus.overflow} !== {3'b001, 1'b1}) begin
      n_bad++; $display("FAIL full_drain got ready=%b ovf=%b want 001/1", bus.req_ready, bus.overflow);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    n_vec++;
    if ({bus.tm_push, bus.overflow} !== {1'b1, 1'b1}) begin
      n_bad++; $display("FAIL full_sticky got push=%b ovf=%b want 1/1", bus.tm_push, bus.overflow);
    end
  endtask

  task automatic test_reset_mid_bt();
    do_reset();
    set_req(0, 1'b1, 32'd3, 1'b0, 1'b1, 16'hFFFF);
    @(negedge clk);
    bus.req_valid = '0;
    bus.bt_req = 1'b1; bus.bt_level = 16'd0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if ({bus.busy, bus.level, bus.tm_backtrack_en} !== {1'b1, 16'd1, 1'b0}) begin
      n_bad++; $display("FAIL midbt_wait got busy=%b level=%0d en=%b want 1/1/0", bus.busy, bus.level, bus.tm_backtrack_en);
    end
    reset = 1'b1;
    bus.bt_req = 1'b0;
    #1;
    n_vec++;
    if ({bus.busy, bus.level, bus.tm_backtrack_en, bus.bt_ack} !== {1'b0, 16'd0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL midbt_reset got busy=%b level=%0d en=%b ack=%b want 0/0/0/0",
                        bus.busy, bus.level, bus.tm_backtrack_en, bus.bt_ack);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.tm_backtrack_done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_vec++;
      if ({bus.bt_ack, bus.busy, bus.tm_backtrack_en} !== 3'b000) begin
        n_bad++; $display("FAIL midbt_after cycle %0d got ack=%b busy=%b en=%b want 0/0/0",
                          k, bus.bt_ack, bus.busy, bus.tm_backtrack_en);
      end
      @(negedge clk);
      bus.tm_backtrack_done = 1'b0;
    end
  endtask

  task automatic test_level_saturate();
    do_reset();
    bus.bt_req = 1'b1; bus.bt_level = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    bus.tm_backtrack_done = 1'b1;
    @(negedge clk);
    bus.tm_backtrack_done = 1'b0;
    #1;
    n_vec++;
    if ({bus.bt_ack, bus.level} !== {1'b1, 16'hFFFF}) begin
      n_bad++; $display("FAIL sat_bt got ack=%b level=%h want 1/ffff", bus.bt_ack, bus.level);
    end
    bus.bt_req = 1'b0;
    @(negedge clk);
    set_req(2, 1'b1, 32'd44, 1'b1, 1'b1, 16'hFFFF);
    @(negedge clk);
    clear_inputs();
    #1;
    n_vec++;
    if ({bus.tm_push, bus.tm_push_level, bus.level} !== {1'b1, 16'hFFFF, 16'hFFFF}) begin
      n_bad++; $display("FAIL sat_push got push=%b lvl=%h level=%h want 1/ffff/ffff",
                        bus.tm_push, bus.tm_push_level, bus.level);
    end
  endtask

  // Random traffic against a cycle-level reference: stage counts the phases of a
  // backtrack (0 idle, 1 issue, 2 wait, 3 settle).
  task automatic test_random();
    int          m_stage, m_level, m_ptr, m_target, occ, g, h, rr;
    bit          m_ovf, m_pend, bt_hold, done;
    logic [15:0] bt_lvl;
    logic [2:0]  vv, exp_ready;
    logic [31:0] vars [NUM_REQ];
    logic        vals [NUM_REQ];
    logic        decs [NUM_REQ];
    logic [15:0] rsns [NUM_REQ];
    logic [31:0] p_var;
    logic        p_val, p_dec;
    logic [15:0] p_lvl, p_rsn;
    do_reset();
    m_stage = 0; m_level = 0; m_ptr = 0; m_target = 0;
    m_ovf = 0; m_pend = 0; bt_hold = 0; bt_lvl = '0;
    p_var = '0; p_val = 0; p_dec = 0; p_lvl = '0; p_rsn = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        vv[r]   = ($urandom_range(0, 2) != 0);
        vars[r] = $urandom;
        vals[r] = 1'($urandom_range(0, 1));
        decs[r] = ($urandom_range(0, 2) == 0);
        rsns[r] = decs[r] ? 16'hFFFF : 16'($urandom_range(0, 65534));
        set_req(r, vv[r], vars[r], vals[r], decs[r], rsns[r]);
      end
      if (!bt_hold && $urandom_range(0, 19) == 0) begin
        bt_hold = 1;
        bt_lvl  = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 6));
      end
      bus.bt_req   = bt_hold;
      bus.bt_level = bt_lvl;
      case ($urandom_range(0, 9))
        0:       h = 256;
        1:       h = 255;
        2:       h = 254;
        default: h = $urandom_range(0, 60);
      endcase
      bus.tm_height = 16'(h);
      done = (m_stage == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0);
      bus.tm_backtrack_done = done;
      #1;
      occ = h + (m_pend ? 1 : 0);
      g = -1;
      if (m_stage == 0 && !bt_hold && occ < MAX_VARS) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          rr = (m_ptr + k) % NUM_REQ;
          if (g < 0 && vv[rr]) g = rr;
        end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;

      n_vec++;
      if (bus.req_ready !== exp_ready) begin
        n_bad++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, bus.req_ready, exp_ready);
      end
      n_vec++;
      if (bus.tm_push !== m_pend) begin
        n_bad++; $display("FAIL rnd_push cyc %0d got %b want %b", cyc, bus.tm_push, m_pend);
      end
      if (m_pend) begin
        n_vec++;
        if ({bus.tm_push_var, bus.tm_push_value, bus.tm_push_level, bus.tm_push_is_decision, bus.tm_push_reason}
            !== {p_var, p_val, p_lvl, p_dec, p_rsn}) begin
          n_bad++; $display("FAIL rnd_push_data cyc %0d got %h/%b/%h/%b/%h want %h/%b/%h/%b/%h", cyc,
                            bus.tm_push_var, bus.tm_push_value, bus.tm_push_level, bus.tm_push_is_decision,
                            bus.tm_push_reason, p_var, p_val, p_lvl, p_dec, p_rsn);
        end
      end
      n_vec++;
      if ({bus.tm_backtrack_en, bus.bt_ack, bus.busy} !== {m_stage == 1, m_stage == 3, m_stage != 0}) begin
        n_bad++; $display("FAIL rnd_bt_ctl cyc %0d got en=%b ack=%b busy=%b want stage %0d",
                          cyc, bus.tm_backtrack_en, bus.bt_ack, bus.busy, m_stage);
      end
      if (m_stage == 1) begin
        n_vec++;
        if (bus.tm_backtrack_to_level !== 16'(m_target)) begin
          n_bad++; $display("FAIL rnd_bt_target cyc %0d got %h want %h", cyc, bus.tm_backtrack_to_level, 16'(m_target));
        end
      end
      n_vec++;
      if (bus.level !== 16'(m_level)) begin
        n_bad++; $display("FAIL rnd_level cyc %0d got %h want %h", cyc, bus.level, 16'(m_level));
      end
      n_vec++;
      if (bus.overflow !== m_ovf) begin
        n_bad++; $display("FAIL rnd_overflow cyc %0d got %b want %b", cyc, bus.overflow, m_ovf);
      end

      if (vv != 3'b000 && occ >= MAX_VARS) m_ovf = 1;
      m_pend = (g >= 0);
      if (g >= 0) begin
        p_var = vars[g]; p_val = vals[g]; p_dec = decs[g]; p_rsn = rsns[g];
        if (decs[g]) begin
          if (m_level < 65535) m_level = m_level + 1;
          p_lvl = 16'(m_level);
        end else begin
          p_lvl = 16'(m_level);
        end
        m_ptr = (g + 1) % NUM_REQ;
      end
      case (m_stage)
        0: if (bt_hold) begin m_target = int'(bt_lvl); m_stage = 1; end
        1: m_stage = 2;
        2: if (done) begin m_level = m_target; m_stage = 3; end
        default: begin m_stage = 0; bt_hold = 0; end
      endcase
      @(negedge clk);
    end
    clear_inputs();
  endtask

`ifdef TRAIL_SCHED_STATS_EN
  task automatic test_stats();
    do_reset();
    set_req(0, 1'b1, 32'd1, 1'b0, 1'b0, 16'h0001);
    repeat (5) @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    bus.tm_height = 16'd256;
    bus.req_valid = 3'b001;
    repeat (3) @(negedge clk);
    bus.req_valid = '0;
    bus.tm_height = 16'd0;
    bus.bt_req = 1'b1; bus.bt_level = 16'd0;
    @(negedge clk);
    @(negedge clk);
    bus.tm_backtrack_done = 1'b1;
    @(negedge clk);
    bus.tm_backtrack_done = 1'b0;
    bus.bt_req = 1'b0;
    @(negedge clk);
    #1;
    n_vec++;
    if ({bus.stat_pushes, bus.stat_backtracks, bus.stat_stall_cycles} !== {32'd5, 32'd1, 32'd3}) begin
      n_bad++; $display("FAIL stats got pushes=%0d bts=%0d stalls=%0d want 5/1/3",
                        bus.stat_pushes, bus.stat_backtracks, bus.stat_stall_cycles);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_implied_push();
    test_backtrack();
    test_full();
    test_reset_mid_bt();
    test_level_saturate();
    test_random();
`ifdef TRAIL_SCHED_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
